// File: rtl/turn_ctrl_pkg.sv
// Shared types and constants for the N-player turn controller.
package turn_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, ORDER, START, ATTACK, RANDOM, CHECK, OVER} state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every cycle regardless of game state.
module lfsr16
    import turn_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= LFSR_SEED;
        else      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
endmodule

// File: rtl/turn_ctrl_n.sv
// N-player turn controller: setup sequencing, per-turn timeout with random shot,
// CPU players, hit tally and game-over detection.
module turn_ctrl_n
    import turn_ctrl_pkg::*;
#(
    parameter int N_PLAYERS   = 2,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int SHIP_CELLS  = 9,
    parameter int COORD_W     = 3,
    localparam int PW = $clog2(N_PLAYERS),
    localparam int HW = $clog2(SHIP_CELLS + 1)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 select,
    input  logic [PW-1:0]        first_player,
    input  logic [N_PLAYERS-1:0] human_mask,
    input  logic                 attack_done,
    input  logic                 hit,
    output logic [N_PLAYERS-1:0] en_attack,
    output logic                 en_random,
    output logic [COORD_W-1:0]   rand_x,
    output logic [COORD_W-1:0]   rand_y,
    output logic                 en_check,
    output logic [PW-1:0]        active_player,
    output logic [PW-1:0]        target_player,
    output logic [31:0]          time_left,
    output logic                 gameover,
    output logic [PW-1:0]        winner
);
    state_t                     state;
    logic [15:0]                q;
    logic                       unused_q;
    logic [N_PLAYERS-1:0][HW-1:0] hits;
    logic                       hit_q;
    logic [HW-1:0]              cur_hits, new_hits;
    logic [PW-1:0]              fp_sel, next_player;

    lfsr16 u_lfsr (.clk(clk), .rst(rst), .q(q));
    assign unused_q = ^q;

    function automatic logic [PW-1:0] succ(input logic [PW-1:0] p);
        return (p == PW'(N_PLAYERS - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        fp_sel      = ({1'b0, first_player} < (PW+1)'(N_PLAYERS)) ? first_player : '0;
        next_player = succ(active_player);
        cur_hits    = hits[target_player];
        new_hits    = (hit_q && cur_hits != HW'(SHIP_CELLS)) ? cur_hits + HW'(1) : cur_hits;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            en_attack     <= '0;
            en_random     <= 1'b0;
            en_check      <= 1'b0;
            rand_x        <= '0;
            rand_y        <= '0;
            active_player <= '0;
            target_player <= '0;
            time_left     <= '0;
            gameover      <= 1'b0;
            winner        <= '0;
            hit_q         <= 1'b0;
            hits          <= '0;
        end else begin
            en_check <= 1'b0;
            case (state)
                IDLE:  if (select) state <= SETUP;
                SETUP: if (select) state <= ORDER;
                ORDER: if (select) begin
                    state         <= START;
                    active_player <= fp_sel;
                    target_player <= succ(fp_sel);
                end
                START: if (human_mask[active_player]) begin
                    state     <= ATTACK;
                    en_attack <= N_PLAYERS'(1) << active_player;
                    time_left <= 32'(TIMEOUT_CYC - 1);
                end else begin
                    state     <= RANDOM;
                    en_random <= 1'b1;
                    rand_x    <= q[COORD_W-1:0];
                    rand_y    <= q[2*COORD_W-1:COORD_W];
                end
                // A shot resolved on the last timer cycle still counts as manual
                ATTACK: if (attack_done) begin
                    state     <= CHECK;
                    en_attack <= '0;
                    time_left <= '0;
                    hit_q     <= hit;
                    en_check  <= 1'b1;
                end else if (time_left == '0) begin
                    state     <= RANDOM;
                    en_attack <= '0;
                    en_random <= 1'b1;
                    rand_x    <= q[COORD_W-1:0];
                    rand_y    <= q[2*COORD_W-1:COORD_W];
                end else begin
                    time_left <= time_left - 32'd1;
                end
                RANDOM: if (attack_done) begin
                    state     <= CHECK;
                    en_random <= 1'b0;
                    hit_q     <= hit;
                    en_check  <= 1'b1;
                end
                CHECK: begin
                    hits[target_player] <= new_hits;
                    if (new_hits == HW'(SHIP_CELLS)) begin
                        state    <= OVER;
                        gameover <= 1'b1;
                        winner   <= active_player;
                    end else begin
                        state         <= START;
                        active_player <= next_player;
                        target_player <= succ(next_player);
                    end
                end
                OVER:    ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_turn_ctrl_n.sv
// Scoreboard bench for turn_ctrl_n: scripted scenarios plus randomized full games.
module tb_turn_ctrl_n;
    localparam int N = 2, TO = 8, SC = 2, CW = 3, PW = 1;

    logic          clk = 1'b0, rst = 1'b0, select = 1'b0, attack_done = 1'b0, hit = 1'b0;
    logic [PW-1:0] first_player = '0;
    logic [N-1:0]  human_mask = '1;
    logic [N-1:0]  en_attack;
    logic          en_random, en_check, gameover;
    logic [CW-1:0] rand_x, rand_y;
    logic [PW-1:0] active_player, target_player, winner;
    logic [31:0]   time_left;

    turn_ctrl_n #(.N_PLAYERS(N), .TIMEOUT_CYC(TO), .SHIP_CELLS(SC), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst), .select(select), .first_player(first_player),
        .human_mask(human_mask), .attack_done(attack_done), .hit(hit),
        .en_attack(en_attack), .en_random(en_random), .rand_x(rand_x), .rand_y(rand_y),
        .en_check(en_check), .active_player(active_player), .target_player(target_player),
        .time_left(time_left), .gameover(gameover), .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct { int act; int tgt; bit over; int win; } shot_t;
    shot_t exp_q[$];
    int    n_checks = 0, n_fail = 0, rnd_rises = 0;
    int    m_hits[N];
    int    m_active;
    bit    m_over;
    logic [15:0] lf_cur = 16'hACE1, lf_prev = 16'hACE1;
    bit          pend = 1'b0, was_rnd = 1'b0;
    shot_t       pshot;
    logic [2*CW-1:0] held = '0;

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Reference sequence: shift left, feedback from taps 16,14,13,11
    always @(posedge clk) begin
        if (!rst) begin
            lf_cur  = 16'hACE1;
            lf_prev = 16'hACE1;
        end else begin
            lf_prev = lf_cur;
            lf_cur  = {lf_cur[14:0], lf_cur[15] ^ lf_cur[13] ^ lf_cur[12] ^ lf_cur[10]};
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                check("gameover_after_check", gameover, pshot.over);
                if (pshot.over) check("winner", winner, pshot.win);
            end
            if (en_check) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL en_check: strobe with no shot outstanding");
                end else begin
                    pshot = exp_q.pop_front();
                    check("check_active", active_player, pshot.act);
                    check("check_target", target_player, pshot.tgt);
                    pend = 1'b1;
                end
            end
            if (en_random && !was_rnd) begin
                rnd_rises++;
                held = lf_prev[2*CW-1:0];
                check("rand_latch", {rand_y, rand_x}, held);
            end else if (en_random) begin
                check("rand_hold", {rand_y, rand_x}, held);
            end
            if (en_attack == '0) check("time_left_outside_attack", time_left, 0);
            was_rnd = en_random;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_en_attack"}, en_attack, 0);
        check({tag, "_en_random"}, en_random, 0);
        check({tag, "_en_check"}, en_check, 0);
        check({tag, "_rand"}, {rand_y, rand_x}, 0);
        check({tag, "_active"}, active_player, 0);
        check({tag, "_target"}, target_player, 0);
        check({tag, "_time_left"}, time_left, 0);
        check({tag, "_gameover"}, gameover, 0);
        check({tag, "_winner"}, winner, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) m_hits[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic pulse_select();
        select = 1'b1;
        @(posedge clk); #1 select = 1'b0;
    endtask

    task automatic start_game(input int fp, input logic [N-1:0] mask);
        human_mask   = mask;
        first_player = fp[PW-1:0];
        m_active     = (fp < N) ? fp : 0;
        m_over       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_select();
            if (i < 2) begin @(posedge clk); #1; end
        end
    endtask

    task automatic turn_begin();
        int k = 0;
        while (en_attack == '0 && !en_random && k < 50) begin
            @(negedge clk); k++;
        end
        if (k >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL turn_start: no attack or random enable within 50 cycles");
        end else if (human_mask[m_active]) begin
            check("turn_attack_onehot", en_attack, longint'(1) << m_active);
        end else begin
            check("turn_random", en_random, 1);
            check("turn_cpu_no_attack", en_attack, 0);
        end
    endtask

    // Model the shot at the rule level, queue the expected CHECK, then fire
    task automatic turn_shot(input int delay, input bit h);
        shot_t s;
        s.act = m_active;
        s.tgt = (m_active + 1) % N;
        if (h && m_hits[s.tgt] < SC) m_hits[s.tgt]++;
        s.over = (m_hits[s.tgt] == SC);
        s.win  = m_active;
        if (s.over) m_over = 1'b1;
        else        m_active = (m_active + 1) % N;
        exp_q.push_back(s);
        repeat (delay) @(posedge clk);
        #1 attack_done = 1'b1; hit = h;
        @(posedge clk); #1 attack_done = 1'b0; hit = 1'b0;
    endtask

    initial begin
        int k, r0, t;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < N; i++) m_hits[i] = 0;

        // First player 1, human; START then ATTACK with full timer
        start_game(1, 2'b11);
        @(negedge clk);
        check("start_en_attack", en_attack, 0);
        check("start_active", active_player, 1);
        @(negedge clk);
        check("attack_en_attack", en_attack, 2'b10);
        check("attack_active", active_player, 1);
        check("attack_target", target_player, 0);
        check("attack_time_left", time_left, TO - 1);
        turn_begin();

        // Timeout: random shot appears TO cycles after ATTACK entry
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            k = i;
            if (en_random) break;
            check("time_left_countdown", time_left, TO - 1 - i);
        end
        check("timeout_cycles", k, TO);
        check("timeout_en_attack", en_attack, 0);
        turn_shot(3, 1'b0);

        // Shot lands exactly when the timer reaches zero
        turn_begin();
        human_mask = 2'b01;
        r0 = rnd_rises;
        turn_shot(TO - 1, 1'b1);
        @(negedge clk);
        check("same_cycle_en_check", en_check, 1);
        check("same_cycle_no_random", rnd_rises - r0, 0);

        // Player 1 is CPU now: straight to a random shot
        @(posedge clk); #1;
        turn_begin();
        turn_shot(3, 1'b0);
        turn_begin();
        turn_shot(2, 1'b1);
        repeat (3) @(posedge clk); #1;

        // Game over is terminal
        pulse_select();
        attack_done = 1'b1; hit = 1'b1;
        @(posedge clk); #1 attack_done = 1'b0; hit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("over_sticky", gameover, 1);
        check("over_winner", winner, 0);
        check("over_en_attack", en_attack, 0);
        check("over_en_random", en_random, 0);
        @(posedge clk); #1;

        // Reset mid-RANDOM after both players have scored
        do_reset();
        start_game(0, 2'b00);
        turn_begin(); turn_shot(2, 1'b1);
        turn_begin(); turn_shot(1, 1'b1);
        turn_begin();
        @(posedge clk); #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        exp_q.delete();
        for (int i = 0; i < N; i++) m_hits[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("post_reset_idle");
        @(posedge clk); #1;

        // Randomized games; stale hit counters would end these early
        for (int g = 0; g < 4; g++) begin
            if (g > 0) do_reset();
            start_game($urandom_range(0, N - 1), N'($urandom_range(0, 3)));
            t = 0;
            while (!m_over && t < 100) begin
                turn_begin();
                turn_shot($urandom_range(1, 12), 1'($urandom_range(0, 1)));
                t++;
            end
            check("game_finished", m_over, 1);
            repeat (3) @(posedge clk); #1;
        end

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
